mem_port_arbiter: RTL and testbench

Arbitrates one single-ported unified memory between the CPU's instruction-fetch requester and its data-memory requester, replacing the separate instruction and data memories. It holds a three-state FSM, latches the winning command, and drives the memory until the memory's ready. It then returns read data or a write acknowledge to the winner. Data accesses have priority; a saturating starvation counter guarantees fetch progress, and halt blocks new fetches.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// State and requester encodings plus default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } src_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data.
// Data has priority; a saturating starvation counter forces fetch progress.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  state_t        state;
  state_t        state_nx;
  src_t          win;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nx;
  logic          if_pend;
  logic          if_win;
  logic          dm_win;
  logic          grant;
  logic          done;

  assign if_pend = if_req & ~hlt;
  assign if_win  = if_pend & (~dm_req | (starve_cnt == SMAX));
  assign dm_win  = dm_req & ~if_win;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    starve_nx = starve_cnt;
    win       = SRC_DM;
    grant     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          if_win: begin
            state_nx  = BUSY_IF;
            win       = SRC_IF;
            grant     = 1'b1;
            starve_nx = '0;
          end
          dm_win: begin
            state_nx = BUSY_DM;
            grant    = 1'b1;
            if (!if_pend)
              starve_nx = '0;
            else if (starve_cnt != SMAX)
              starve_nx = starve_cnt + 1'b1;
          end
          default: ;
        endcase
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_rdy) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      starve_cnt <= starve_nx;
      if_valid   <= done & (state == BUSY_IF);
      dm_valid   <= done & (state == BUSY_DM);
      if (grant) begin
        if (win == SRC_IF) begin
          mem_addr <= if_addr;
          mem_we   <= 1'b0;
        end else begin
          mem_addr  <= dm_addr;
          mem_we    <= dm_we;
          mem_wdata <= dm_wdata;
        end
      end else if (done) begin
        mem_we <= 1'b0;
      end
      if (done && state == BUSY_IF)
        if_rdata <= mem_rdata;
      // writes leave the last read data visible
      if (done && state == BUSY_DM && !mem_we)
        dm_rdata <= mem_rdata;
    end
  end

  assign mem_en = (state != IDLE);
  assign if_gnt = (state == BUSY_IF);
  assign dm_gnt = (state == BUSY_DM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table,
// directed corner sequences and randomized traffic vs a reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n, hlt;
  logic          if_req, dm_req, dm_we, mem_rdy;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, mem_rdata, mem_wdata;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          if_gnt, if_valid, dm_gnt, dm_valid;
  logic          mem_en, mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data),
  // the consecutive-data-grant count and the architecturally visible outputs.
  int            m_own, m_cnt;
  logic          m_we, m_ifv, m_dmv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_ifr, m_dmr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit fetch_pend;
    if (!rst_n) begin
      m_own = 0; m_cnt = 0; m_we = 0; m_ifv = 0; m_dmv = 0;
      m_addr = '0; m_wdata = '0; m_ifr = '0; m_dmr = '0;
    end else begin
      m_ifv = 0;
      m_dmv = 0;
      fetch_pend = if_req && !hlt;
      if (m_own == 0) begin
        if (fetch_pend && (!dm_req || m_cnt == SMAX)) begin
          m_own = 1; m_addr = if_addr; m_we = 0; m_cnt = 0;
        end else if (dm_req) begin
          m_own = 2; m_addr = dm_addr; m_we = dm_we;
          m_wdata = dm_wdata;
          m_cnt = fetch_pend ? ((m_cnt + 1 > SMAX) ? SMAX : m_cnt + 1) : 0;
        end
      end else if (mem_rdy) begin
        if (m_own == 1) begin
          m_ifv = 1; m_ifr = mem_rdata;
        end else begin
          m_dmv = 1;
          if (!m_we) m_dmr = mem_rdata;
        end
        m_own = 0;
        m_we  = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string t);
    chk({t, ".if_gnt"},    if_gnt,    m_own == 1);
    chk({t, ".dm_gnt"},    dm_gnt,    m_own == 2);
    chk({t, ".mem_en"},    mem_en,    m_own != 0);
    chk({t, ".mem_we"},    mem_we,    m_we);
    chk({t, ".mem_addr"},  mem_addr,  m_addr);
    chk({t, ".mem_wdata"}, mem_wdata, m_wdata);
    chk({t, ".if_valid"},  if_valid,  m_ifv);
    chk({t, ".if_rdata"},  if_rdata,  m_ifr);
    chk({t, ".dm_valid"},  dm_valid,  m_dmv);
    chk({t, ".dm_rdata"},  dm_rdata,  m_dmr);
  endtask

  typedef struct {
    logic        rst_n, hlt, if_req;
    logic [15:0] if_addr;
    logic        dm_req, dm_we;
    logic [15:0] dm_addr, dm_wdata;
    logic        rdy;
    logic [15:0] rdata;
    logic        e_ifg, e_dmg, e_en, e_we;
    logic [15:0] e_addr, e_wdata;
    logic        e_ifv;
    logic [15:0] e_ifr;
    logic        e_dmv;
    logic [15:0] e_dmr;
  } vec_t;

  vec_t vt[15];

  initial begin
    int ng, ifg, dmg, first, wcnt, vcnt;
    int order[8];
    int exp_order[8];
    string nm;

    vt[0]  = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
               0,0,0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000};
    vt[1]  = '{1,0,1,16'h0010,0,0,16'h0000,16'h0000,1,16'hB123,
               1,0,1,0,16'h0010,16'h0000,0,16'h0000,0,16'h0000};
    vt[2]  = '{1,0,1,16'h0010,0,0,16'h0000,16'h0000,1,16'hB123,
               0,0,0,0,16'h0010,16'h0000,1,16'hB123,0,16'h0000};
    vt[3]  = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,1,16'hB123,
               0,0,0,0,16'h0010,16'h0000,0,16'hB123,0,16'h0000};
    vt[4]  = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
               0,0,0,0,16'h0010,16'h0000,0,16'hB123,0,16'h0000};
    vt[5]  = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,1,16'hFFFF,
               0,0,0,0,16'h0010,16'h0000,0,16'hB123,0,16'h0000};
    vt[6]  = '{1,0,0,16'h0000,1,0,16'h0022,16'h0000,0,16'h0000,
               0,1,1,0,16'h0022,16'h0000,0,16'hB123,0,16'h0000};
    vt[7]  = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
               0,1,1,0,16'h0022,16'h0000,0,16'hB123,0,16'h0000};
    vt[8]  = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,1,16'h1357,
               0,0,0,0,16'h0022,16'h0000,0,16'hB123,1,16'h1357};
    vt[9]  = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
               0,0,0,0,16'h0022,16'h0000,0,16'hB123,0,16'h1357};
    vt[10] = '{1,0,0,16'h0000,1,1,16'h0033,16'hC0DE,1,16'h9999,
               0,1,1,1,16'h0033,16'hC0DE,0,16'hB123,0,16'h1357};
    vt[11] = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,1,16'h9999,
               0,0,0,0,16'h0033,16'hC0DE,0,16'hB123,1,16'h1357};
    vt[12] = '{1,0,1,16'h0044,0,0,16'h0000,16'h0000,1,16'h0000,
               1,0,1,0,16'h0044,16'hC0DE,0,16'hB123,0,16'h1357};
    vt[13] = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,1,16'hABCD,
               0,0,0,0,16'h0044,16'hC0DE,1,16'hABCD,0,16'h1357};
    vt[14] = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
               0,0,0,0,16'h0044,16'hC0DE,0,16'hABCD,0,16'h1357};

    for (int i = 0; i < 15; i++) begin
      rst_n = vt[i].rst_n; hlt = vt[i].hlt;
      if_req = vt[i].if_req; if_addr = vt[i].if_addr;
      dm_req = vt[i].dm_req; dm_we = vt[i].dm_we;
      dm_addr = vt[i].dm_addr; dm_wdata = vt[i].dm_wdata;
      mem_rdy = vt[i].rdy; mem_rdata = vt[i].rdata;
      tick();
      nm = $sformatf("vec%0d", i);
      chk({nm, ".if_gnt"},    if_gnt,    vt[i].e_ifg);
      chk({nm, ".dm_gnt"},    dm_gnt,    vt[i].e_dmg);
      chk({nm, ".mem_en"},    mem_en,    vt[i].e_en);
      chk({nm, ".mem_we"},    mem_we,    vt[i].e_we);
      chk({nm, ".mem_addr"},  mem_addr,  vt[i].e_addr);
      chk({nm, ".mem_wdata"}, mem_wdata, vt[i].e_wdata);
      chk({nm, ".if_valid"},  if_valid,  vt[i].e_ifv);
      chk({nm, ".if_rdata"},  if_rdata,  vt[i].e_ifr);
      chk({nm, ".dm_valid"},  dm_valid,  vt[i].e_dmv);
      chk({nm, ".dm_rdata"},  dm_rdata,  vt[i].e_dmr);
    end

    // data write, three wait cycles
    dm_req = 1; dm_we = 1; dm_addr = 16'h00F0; dm_wdata = 16'h5A5A;
    mem_rdy = 0; mem_rdata = 16'hEEEE;
    tick();
    check_model("wr");
    wcnt = mem_we ? 1 : 0;
    vcnt = dm_valid ? 1 : 0;
    dm_req = 0;
    for (int i = 0; i < 5; i++) begin
      mem_rdy = (i == 3);
      tick();
      check_model("wr");
      wcnt += mem_we ? 1 : 0;
      vcnt += dm_valid ? 1 : 0;
    end
    chk("wr.we_cycles", wcnt, 4);
    chk("wr.valid_pulses", vcnt, 1);
    chk("wr.rdata_kept", dm_rdata, 16'h1357);

    // starvation: data always requesting, fetch waiting
    exp_order = '{2, 2, 2, 1, 2, 2, 2, 1};
    order = '{0, 0, 0, 0, 0, 0, 0, 0};
    if_req = 1; if_addr = 16'h0100;
    dm_req = 1; dm_we = 0; dm_addr = 16'h0200;
    mem_rdy = 1;
    ng = 0;
    for (int i = 0; i < 24; i++) begin
      mem_rdata = 16'(i);
      tick();
      check_model("stv");
      if ((if_gnt || dm_gnt) && ng < 8) begin
        order[ng] = if_gnt ? 1 : 2;
        ng++;
      end
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("stv.grant%0d", i), order[i], exp_order[i]);

    // halt masks new fetch grants
    hlt = 1; ifg = 0; dmg = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_model("hlt");
      ifg += if_gnt ? 1 : 0;
      dmg += dm_gnt ? 1 : 0;
    end
    chk("hlt.if_grants", ifg, 0);
    chk("hlt.dm_granted", dmg >= 6, 1);
    hlt = 0; dm_req = 0; first = 0;
    for (int i = 0; i < 8 && first == 0; i++) begin
      tick();
      check_model("unhlt");
      if (if_gnt) first = 1;
      else if (dm_gnt) first = 2;
    end
    chk("unhlt.first_grant", first, 1);

    // reset in the middle of a data access
    if_req = 0; dm_req = 0; mem_rdy = 1;
    repeat (3) tick();
    check_model("pre_rst");
    dm_req = 1; dm_we = 0; dm_addr = 16'h0077; mem_rdy = 0;
    tick();
    chk("rst.busy_dm_gnt", dm_gnt, 1);
    dm_req = 0; rst_n = 0;
    tick();
    check_model("rst.low");
    chk("rst.mem_en", mem_en, 0);
    chk("rst.mem_addr", mem_addr, 0);
    rst_n = 1; mem_rdy = 1; mem_rdata = 16'h4444;
    tick();
    chk("rst.late_rdy_valid", dm_valid, 0);
    chk("rst.late_rdy_en", mem_en, 0);
    check_model("rst.after");
    tick();
    chk("rst.no_valid_later", dm_valid, 0);
    chk("rst.rdata_clear", dm_rdata, 0);

    // mem_rdy toggling while idle
    for (int i = 0; i < 6; i++) begin
      mem_rdy = i[0];
      mem_rdata = 16'hF0F0;
      tick();
      chk("idle.mem_en", mem_en, 0);
      chk("idle.if_valid", if_valid, 0);
      chk("idle.dm_valid", dm_valid, 0);
    end

    // randomized traffic
    hlt = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) hlt = ~hlt;
      if (!if_req || if_valid) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = 16'($urandom);
      end
      if (!dm_req || dm_valid) begin
        dm_req   = ($urandom_range(0, 1) != 0);
        dm_we    = ($urandom_range(0, 1) != 0);
        dm_addr  = 16'($urandom);
        dm_wdata = 16'($urandom);
      end
      mem_rdy   = ($urandom_range(0, 2) != 0);
      mem_rdata = 16'($urandom);
      tick();
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
